// File: rtl/alu_rs.sv
// ALU reservation station: buffers dispatched ops, snoops the B/L buses, issues one ready op per cycle.
// Optional ALU_RS_DIRECT_ISSUE_EN lets a ready dispatch bypass the buffer when nothing stored is ready.
module alu_rs #(
  parameter int RS_SIZE = 8,
  parameter int OP_LOG  = 6,
  parameter int ROB_LOG = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               rdy,
  input  logic               clr,
  input  logic               D_valid,
  input  logic [OP_LOG-1:0]  D_op,
  input  logic [31:0]        D_Vj,
  input  logic [31:0]        D_Vk,
  input  logic               D_Rj,
  input  logic               D_Rk,
  input  logic [ROB_LOG-1:0] D_Qj,
  input  logic [ROB_LOG-1:0] D_Qk,
  input  logic [31:0]        D_Imm,
  input  logic [31:0]        D_CurPC,
  input  logic [ROB_LOG-1:0] D_DestRob,
  output logic               full,
  input  logic               B_enable,
  input  logic [31:0]        B_value,
  input  logic [ROB_LOG-1:0] B_RobId,
  input  logic               L_enable,
  input  logic [31:0]        L_value,
  input  logic [ROB_LOG-1:0] L_RobId,
  output logic               RS_valid,
  output logic [OP_LOG-1:0]  RS_op,
  output logic [31:0]        RS_Vj,
  output logic [31:0]        RS_Vk,
  output logic [31:0]        RS_Imm,
  output logic [31:0]        RS_CurPC,
  output logic [ROB_LOG-1:0] RS_DestRob
);
  localparam int IDX_W = $clog2(RS_SIZE);
  localparam logic [OP_LOG-1:0] OP_NOP = '0;

  logic [RS_SIZE-1:0] busy_q, busy_d, rj_q, rk_q;
  logic [OP_LOG-1:0]  op_q   [RS_SIZE];
  logic [31:0]        vj_q   [RS_SIZE];
  logic [31:0]        vk_q   [RS_SIZE];
  logic [31:0]        imm_q  [RS_SIZE];
  logic [31:0]        pc_q   [RS_SIZE];
  logic [ROB_LOG-1:0] qj_q   [RS_SIZE];
  logic [ROB_LOG-1:0] qk_q   [RS_SIZE];
  logic [ROB_LOG-1:0] dest_q [RS_SIZE];

  // Returns {ready, value}; the B bus wins when both buses carry the same tag.
  function automatic logic [32:0] snoop(input logic r, input logic [31:0] v,
                                        input logic [ROB_LOG-1:0] q);
    if (r)                                snoop = {1'b1, v};
    else if (B_enable && (B_RobId == q))  snoop = {1'b1, B_value};
    else if (L_enable && (L_RobId == q))  snoop = {1'b1, L_value};
    else                                  snoop = {1'b0, v};
  endfunction

  logic [RS_SIZE-1:0] ready_vec;
  logic               any_ready;
  logic [IDX_W-1:0]   sel_idx, free_idx;
  logic [32:0]        dj, dk;
  logic [32:0]        wj [RS_SIZE];
  logic [32:0]        wk [RS_SIZE];
  logic               direct, do_dispatch;

  always_comb begin
    ready_vec = busy_q & rj_q & rk_q;
    any_ready = 1'b0;
    sel_idx   = '0;
    free_idx  = '0;
    for (int i = RS_SIZE - 1; i >= 0; i--) begin
      if (ready_vec[i]) begin
        any_ready = 1'b1;
        sel_idx   = IDX_W'(i);
      end
      if (!busy_q[i]) free_idx = IDX_W'(i);
    end
    for (int i = 0; i < RS_SIZE; i++) begin
      wj[i] = snoop(rj_q[i], vj_q[i], qj_q[i]);
      wk[i] = snoop(rk_q[i], vk_q[i], qk_q[i]);
    end
  end

  assign full = &busy_q;
  assign dj   = snoop(D_Rj, D_Vj, D_Qj);
  assign dk   = snoop(D_Rk, D_Vk, D_Qk);

`ifdef ALU_RS_DIRECT_ISSUE_EN
  assign direct = D_valid & dj[32] & dk[32] & ~any_ready;
`else
  assign direct = 1'b0;
`endif

  // A full buffer drops the dispatch even if an entry issues this same edge.
  assign do_dispatch = D_valid & ~full & ~direct;

  always_comb begin
    busy_d = busy_q;
    if (any_ready)   busy_d[sel_idx]  = 1'b0;
    if (do_dispatch) busy_d[free_idx] = 1'b1;
  end

  // Entry payload: only meaningful while busy, so it carries no reset.
  always_ff @(posedge clk) begin
    if (rdy) begin
      for (int i = 0; i < RS_SIZE; i++) begin
        if (do_dispatch && (free_idx == IDX_W'(i))) begin
          op_q[i]   <= D_op;
          rj_q[i]   <= dj[32];
          vj_q[i]   <= dj[31:0];
          qj_q[i]   <= D_Qj;
          rk_q[i]   <= dk[32];
          vk_q[i]   <= dk[31:0];
          qk_q[i]   <= D_Qk;
          imm_q[i]  <= D_Imm;
          pc_q[i]   <= D_CurPC;
          dest_q[i] <= D_DestRob;
        end else if (busy_q[i]) begin
          rj_q[i] <= wj[i][32];
          vj_q[i] <= wj[i][31:0];
          rk_q[i] <= wk[i][32];
          vk_q[i] <= wk[i][31:0];
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rdy) begin
      if (!rst) begin
        busy_q     <= '0;
        RS_valid   <= 1'b0;
        RS_op      <= OP_NOP;
        RS_Vj      <= '0;
        RS_Vk      <= '0;
        RS_Imm     <= '0;
        RS_CurPC   <= '0;
        RS_DestRob <= '0;
      end else if (clr) begin
        busy_q   <= '0;
        RS_valid <= 1'b0;
        RS_op    <= OP_NOP;
      end else begin
        busy_q <= busy_d;
        if (any_ready) begin
          RS_valid   <= 1'b1;
          RS_op      <= op_q[sel_idx];
          RS_Vj      <= vj_q[sel_idx];
          RS_Vk      <= vk_q[sel_idx];
          RS_Imm     <= imm_q[sel_idx];
          RS_CurPC   <= pc_q[sel_idx];
          RS_DestRob <= dest_q[sel_idx];
        end else if (direct) begin
          RS_valid   <= 1'b1;
          RS_op      <= D_op;
          RS_Vj      <= dj[31:0];
          RS_Vk      <= dk[31:0];
          RS_Imm     <= D_Imm;
          RS_CurPC   <= D_CurPC;
          RS_DestRob <= D_DestRob;
        end else begin
          RS_valid <= 1'b0;
          RS_op    <= OP_NOP;
        end
      end
    end
  end

endmodule

// File: tb/tb_alu_rs.sv
// Bench for alu_rs: directed scenarios then random traffic, all checked against a behavioural model.
module tb_alu_rs;
  localparam int N = 8;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, rdy, clr, D_valid, D_Rj, D_Rk;
  logic [5:0]  D_op;
  logic [31:0] D_Vj, D_Vk, D_Imm, D_CurPC;
  logic [3:0]  D_Qj, D_Qk, D_DestRob;
  logic        B_enable, L_enable;
  logic [31:0] B_value, L_value;
  logic [3:0]  B_RobId, L_RobId;
  logic        full, RS_valid;
  logic [5:0]  RS_op;
  logic [31:0] RS_Vj, RS_Vk, RS_Imm, RS_CurPC;
  logic [3:0]  RS_DestRob;

  alu_rs #(.RS_SIZE(N), .OP_LOG(6), .ROB_LOG(4)) dut (
    .clk(clk), .rst(rst), .rdy(rdy), .clr(clr),
    .D_valid(D_valid), .D_op(D_op), .D_Vj(D_Vj), .D_Vk(D_Vk), .D_Rj(D_Rj), .D_Rk(D_Rk),
    .D_Qj(D_Qj), .D_Qk(D_Qk), .D_Imm(D_Imm), .D_CurPC(D_CurPC), .D_DestRob(D_DestRob),
    .full(full),
    .B_enable(B_enable), .B_value(B_value), .B_RobId(B_RobId),
    .L_enable(L_enable), .L_value(L_value), .L_RobId(L_RobId),
    .RS_valid(RS_valid), .RS_op(RS_op), .RS_Vj(RS_Vj), .RS_Vk(RS_Vk),
    .RS_Imm(RS_Imm), .RS_CurPC(RS_CurPC), .RS_DestRob(RS_DestRob)
  );

  int checks = 0;
  int errors = 0;

  typedef struct {
    bit          busy, rj, rk;
    logic [5:0]  op;
    logic [31:0] vj, vk, imm, pc;
    logic [3:0]  qj, qk, dest;
  } ent_t;

  ent_t        m [N];
  logic        e_valid = 1'b0;
  logic [5:0]  e_op = '0;
  logic [31:0] e_vj = '0, e_vk = '0, e_imm = '0, e_pc = '0;
  logic [3:0]  e_dest = '0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Operand as seen on the buses this cycle: {ready, value}.
  function automatic logic [32:0] res(input bit r, input logic [31:0] v, input logic [3:0] q);
    if (r) return {1'b1, v};
    if (B_enable && B_RobId == q) return {1'b1, B_value};
    if (L_enable && L_RobId == q) return {1'b1, L_value};
    return {1'b0, v};
  endfunction

  task automatic model_step();
    int sel, fr;
    bit direct;
    logic [32:0] a, b, w;
    ent_t n [N];
    if (!rdy) return;
    if (!rst) begin
      for (int i = 0; i < N; i++) m[i].busy = 0;
      e_valid = 0; e_op = 0; e_vj = 0; e_vk = 0; e_imm = 0; e_pc = 0; e_dest = 0;
      return;
    end
    if (clr) begin
      for (int i = 0; i < N; i++) m[i].busy = 0;
      e_valid = 0; e_op = 0;
      return;
    end
    sel = -1; fr = -1;
    for (int i = 0; i < N; i++) begin
      if (sel < 0 && m[i].busy && m[i].rj && m[i].rk) sel = i;
      if (fr < 0 && !m[i].busy) fr = i;
    end
    a = res(D_Rj, D_Vj, D_Qj);
    b = res(D_Rk, D_Vk, D_Qk);
    direct = 0;
`ifdef ALU_RS_DIRECT_ISSUE_EN
    direct = D_valid && a[32] && b[32] && sel < 0;
`endif
    n = m;
    for (int i = 0; i < N; i++) if (m[i].busy) begin
      w = res(m[i].rj, m[i].vj, m[i].qj); n[i].rj = w[32]; n[i].vj = w[31:0];
      w = res(m[i].rk, m[i].vk, m[i].qk); n[i].rk = w[32]; n[i].vk = w[31:0];
    end
    if (sel >= 0) begin
      e_valid = 1; e_op = m[sel].op; e_vj = m[sel].vj; e_vk = m[sel].vk;
      e_imm = m[sel].imm; e_pc = m[sel].pc; e_dest = m[sel].dest;
      n[sel].busy = 0;
    end else if (direct) begin
      e_valid = 1; e_op = D_op; e_vj = a[31:0]; e_vk = b[31:0];
      e_imm = D_Imm; e_pc = D_CurPC; e_dest = D_DestRob;
    end else begin
      e_valid = 0; e_op = 0;
    end
    if (D_valid && !direct && fr >= 0) begin
      n[fr].busy = 1; n[fr].op = D_op; n[fr].imm = D_Imm; n[fr].pc = D_CurPC;
      n[fr].dest = D_DestRob; n[fr].qj = D_Qj; n[fr].qk = D_Qk;
      n[fr].rj = a[32]; n[fr].vj = a[31:0]; n[fr].rk = b[32]; n[fr].vk = b[31:0];
    end
    m = n;
  endtask

  task automatic cycle();
    bit ef = 1;
    for (int i = 0; i < N; i++) if (!m[i].busy) ef = 0;
    chk("full", full, ef);
    @(posedge clk);
    model_step();
    #1;
    chk("valid", RS_valid, e_valid);
    chk("op", RS_op, e_op);
    chk("vj", RS_Vj, e_vj);
    chk("vk", RS_Vk, e_vk);
    chk("imm", RS_Imm, e_imm);
    chk("pc", RS_CurPC, e_pc);
    chk("dest", RS_DestRob, e_dest);
  endtask

  task automatic idle();
    rst = 1; rdy = 1; clr = 0;
    D_valid = 0; D_op = 0; D_Vj = 0; D_Vk = 0; D_Rj = 1; D_Rk = 1;
    D_Qj = 0; D_Qk = 0; D_Imm = 0; D_CurPC = 0; D_DestRob = 0;
    B_enable = 0; B_value = 0; B_RobId = 0; L_enable = 0; L_value = 0; L_RobId = 0;
  endtask

  task automatic disp(input logic [5:0] op, input logic [31:0] vj, input logic rj, input logic [3:0] qj,
                      input logic [31:0] vk, input logic rk, input logic [3:0] qk, input logic [3:0] dest);
    D_valid = 1; D_op = op; D_Vj = vj; D_Rj = rj; D_Qj = qj;
    D_Vk = vk; D_Rk = rk; D_Qk = qk; D_DestRob = dest;
    D_Imm = $urandom; D_CurPC = $urandom;
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) cycle();
  endtask

  initial begin
    idle();
    rst = 0;
    for (int i = 0; i < 2; i++) begin
      @(posedge clk); model_step(); #1;
    end
    chk("rst_valid", RS_valid, 0);
    chk("rst_op", RS_op, 0);
    chk("rst_vj", RS_Vj, 0);
    chk("rst_full", full, 0);
    rst = 1;

    // ADD with both operands ready
    disp(6'd1, 32'd5, 1, 4'd0, 32'd7, 1, 4'd0, 4'd3); cycle();
    idle(); run(4);

    // SUB waiting on tag 2, woken by B bus two cycles later
    disp(6'd2, 32'd0, 0, 4'd2, 32'd3, 1, 4'd0, 4'd5); cycle();
    idle(); run(2);
    B_enable = 1; B_RobId = 4'd2; B_value = 32'h100; cycle();
    idle(); run(3);

    // L bus bypass on the dispatch cycle itself
    disp(6'd3, 32'd11, 1, 4'd0, 32'd0, 0, 4'd4, 4'd6);
    L_enable = 1; L_RobId = 4'd4; L_value = 32'd9; cycle();
    idle(); run(3);

    // Fill all entries waiting on tag 1, then release them together
    for (int i = 0; i < N; i++) begin
      disp(6'(10 + i), 32'(i), 0, 4'd1, 32'(100 + i), 1, 4'd0, 4'(i)); cycle();
    end
    idle();
    chk("fill_full", full, 1);
    disp(6'd20, 32'd1, 1, 4'd0, 32'd2, 1, 4'd0, 4'd9); cycle();
    idle(); B_enable = 1; B_RobId = 4'd1; B_value = 32'hABCD; cycle();
    idle(); run(10);

    // Flush with a concurrent dispatch; nothing may issue afterwards
    for (int i = 0; i < 3; i++) begin
      disp(6'(30 + i), 32'd0, 0, 4'd9, 32'd0, 1, 4'd0, 4'(i)); cycle();
    end
    disp(6'd40, 32'd1, 1, 4'd0, 32'd2, 1, 4'd0, 4'd12); clr = 1; cycle();
    idle();
    chk("clr_valid", RS_valid, 0);
    chk("clr_full", full, 0);
    L_enable = 1; L_RobId = 4'd9; L_value = 32'h55; cycle();
    idle(); run(4);

    // Freeze with a ready entry pending; clr during the freeze must be ignored
    disp(6'd41, 32'h77, 1, 4'd0, 32'h88, 1, 4'd0, 4'd7); cycle();
    idle(); rdy = 0;
    for (int i = 0; i < 5; i++) begin
      clr = (i == 2);
      cycle();
    end
    idle(); run(3);

    // Random traffic
    for (int c = 0; c < 600; c++) begin
      rst = ($urandom_range(0, 199) != 0);
      rdy = ($urandom_range(0, 9) != 0);
      clr = ($urandom_range(0, 39) == 0);
      D_valid = ($urandom_range(0, 2) != 0);
      D_op = 6'($urandom_range(1, 63));
      D_Vj = $urandom; D_Vk = $urandom; D_Imm = $urandom; D_CurPC = $urandom;
      D_Rj = 1'($urandom_range(0, 1)); D_Rk = 1'($urandom_range(0, 1));
      D_Qj = 4'($urandom_range(0, 15)); D_Qk = 4'($urandom_range(0, 15));
      D_DestRob = 4'($urandom_range(0, 15));
      B_enable = 1'($urandom_range(0, 1)); B_RobId = 4'($urandom_range(0, 15)); B_value = $urandom;
      L_enable = 1'($urandom_range(0, 1)); L_RobId = 4'($urandom_range(0, 15)); L_value = $urandom;
      cycle();
    end
    idle(); run(12);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/alu_rs.md
# alu_rs

Reservation station feeding the ALU functional unit: the issuing end of the RS→FU interface (`RS_valid/RS_op/RS_Vj/RS_Vk/RS_Imm/RS_DestRob/RS_CurPC`).
- Buffers decoded ALU/branch/jump instructions from dispatch.
- Snoops the ALU and load/store broadcast buses to wake pending operands.
- Issues at most one ready instruction per cycle through a registered output.
- Flushes completely on a misprediction clear.

## Interface
Parameters:
- RS_SIZE, 8, number of entries (power of two, ≥2)
- OP_LOG, 6, opcode width; opcode 0 is OP_NOP
- ROB_LOG, 4, ROB tag width

Ports:
- clk  in  1  clock
- rst  in  1  reset rst, synchronous, active-low
- rdy  in  1  global enable; low freezes all state and outputs
- clr  in  1  synchronous flush (branch mispredict)
- D_valid  in  1  dispatch strobe
- D_op  in  OP_LOG  opcode
- D_Vj, D_Vk  in  32  operand values (valid when matching ready bit is 1)
- D_Rj, D_Rk  in  1  operand ready; dispatcher sets 1 for unused operands
- D_Qj, D_Qk  in  ROB_LOG  producer ROB tag when not ready
- D_Imm, D_CurPC  in  32  immediate, instruction PC
- D_DestRob  in  ROB_LOG  destination ROB tag
- full  out  1  combinational; 1 when all RS_SIZE entries busy
- B_enable, B_value[32], B_RobId[ROB_LOG]  in  ALU broadcast
- L_enable, L_value[32], L_RobId[ROB_LOG]  in  load/store broadcast
- RS_valid  out  1  issue strobe, one cycle per issued instruction
- RS_op  out  OP_LOG
- RS_Vj, RS_Vk, RS_Imm, RS_CurPC  out  32
- RS_DestRob  out  ROB_LOG

## Operation
- Per entry: busy, op, Vj, Vk, Rj, Rk, Qj, Qk, Imm, CurPC, DestRob.
- Dispatch: on D_valid, write into the lowest-index non-busy entry and set busy. D_valid while full is a protocol violation: ignored, no state change.
- Dispatch bypass (always present): if a not-ready dispatched operand's tag matches B_RobId with B_enable, or L_RobId with L_enable, in the same cycle, store the broadcast value with ready=1.
- Wakeup: each busy entry with Rj=0 and Qj matching an enabled bus captures that bus value and sets Rj=1; Rk likewise. If both buses match the same tag, the B bus wins.
- Select: an entry is ready when busy & Rj & Rk, evaluated on registered state. Issue the lowest-index ready entry: copy its fields into the output registers, set RS_valid=1, clear its busy bit.
- No ready entry: RS_valid=0 and RS_op=OP_NOP; data outputs hold their previous values.
- An entry freed by issue is not reusable in the same cycle, because full and the free-slot search use pre-edge state.
- clr: clear all busy bits, RS_valid=0, RS_op=OP_NOP next cycle. clr overrides dispatch, wakeup and issue in that cycle.
- rdy=0: no state or output changes. rst and clr act only when rdy=1; rst has priority over everything.

## Timing
- Reset: all busy=0; RS_valid=0; RS_op=0; RS_Vj=RS_Vk=RS_Imm=RS_CurPC=0; RS_DestRob=0.
- Dispatch with both operands ready at edge t: the entry becomes busy at t, is selected during cycle t+1, and RS_valid is high after edge t+1. Dispatch-to-issue latency is 2 edges.
- Broadcast of the last missing operand at edge t: the operand is captured at t, and RS_valid is high after edge t+1.
- Throughput: 1 issue per cycle. RS_valid is high for exactly one cycle per entry issued.
- full reflects current busy bits with no lookahead, so a dispatch and an issue in the same cycle when full drops the dispatch.

## Configuration
- ALU_RS_DIRECT_ISSUE_EN defined:
  - Applies when no stored entry is ready and the dispatched instruction is ready after bypass, with rdy=1 and clr=0.
  - The instruction is written directly into the output registers at edge t (RS_valid high after t).
  - It never occupies an entry and the buffer is not consulted. This applies even when full=1 if D_valid is otherwise legal.
- Undefined: every dispatch goes through an entry, giving the 2-edge minimum latency.

## Test plan
- Reset, then dispatch ADD (Vj=5, Vk=7, both ready, DestRob=3) -> RS_valid=1 exactly one cycle, 2 edges later (1 with ALU_RS_DIRECT_ISSUE_EN), carrying RS_Vj=5, RS_Vk=7, RS_DestRob=3.
- Dispatch SUB with Rj=0, Qj=2; two cycles later B_enable=1, B_RobId=2, B_value=0x100 -> RS_valid one edge after the broadcast, with RS_Vj=0x100.
- Dispatch with Qk=4 in the same cycle as L_enable=1, L_RobId=4, L_value=9 -> issues with RS_Vk=9, with no hang.
- Fill all 8 entries with ops waiting on tag 1 -> full=1; broadcast tag 1 -> entries 0..7 issue in index order on 8 consecutive cycles.
- Fill 3 entries, assert clr together with D_valid -> RS_valid=0 and full=0 afterwards, and no later issue from any of the 4 instructions.
- Hold rdy=0 while a ready entry exists -> RS_valid is unchanged for 5 cycles, then issues one edge after rdy returns to 1.
